hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- ID-stage hazard detector and pipeline-freeze controller for the 5-stage MIPS core. It works alongside the forwarding unit.
- It decides when a dependence cannot be resolved by forwarding: load-use, branch-compare in ID, and HI/LO use while the multi-cycle mul/div is busy. In those cases it stalls IF/ID and inserts an ID/EX bubble.
- It freezes the whole pipeline while data memory is not ready.
- It also keeps a saturating stall-cycle performance counter.

Parameters:
- MULDIV_LAT, 4, cycles the mul/div unit stays busy after a mul/div leaves EX; 0 means never busy
- CNT_W, 16, width of StallCount

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- IfIdRegRs  in  5  rs of the instruction in ID
- IfIdRegRt  in  5  rt of the instruction in ID
- IfIdUsesRt  in  1  ID instruction reads rt as a source
- IfIdUsesHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mul/div
- Branch  in  1  ID instruction is beq/bne
- BranchTaken  in  1  ID compare result, valid when Branch=1
- IdExMemRead  in  1  EX instruction is a load
- IdExRegWrite  in  1  EX instruction writes the register file
- IdExRegDst  in  5  destination register of the EX instruction, after the RegDst mux
- IdExMulDiv  in  1  EX instruction is mul/div
- ExMemMemRead  in  1  MEM instruction is a load
- ExMemMemWrite  in  1  MEM instruction is a store
- ExMemRegRd  in  5  destination register of the MEM instruction
- DMemReady  in  1  data memory completes its access this cycle
- PCWrite  out  1  PC update enable
- IfIdWrite  out  1  IF/ID register enable
- IfIdFlush  out  1  zero IF/ID; taken branch squashes the fetched instruction
- IdExBubble  out  1  load zeros into the ID/EX control fields
- PipeWrite  out  1  enable for ID/EX, EX/MEM and MEM/WB
- MulDivBusy  out  1  mul/div unit busy
- StallCount  out  CNT_W  cycles with Stall or Freeze, saturating

Behaviour:

Combinational terms (register 0 never matches):
- MatchEx(r) = IdExRegDst!=0 && IdExRegDst==r
- MatchMem(r) = ExMemRegRd!=0 && ExMemRegRd==r
- SrcRt = IfIdUsesRt || Branch

Hazard conditions:
- LoadUse = IdExMemRead && (MatchEx(Rs) || (SrcRt && MatchEx(Rt)))
- BrEx = Branch && (IdExRegWrite || IdExMemRead) && (MatchEx(Rs) || MatchEx(Rt))
- BrMem = Branch && ExMemMemRead && (MatchMem(Rs) || MatchMem(Rt))
- HiLo = IfIdUsesHiLo && MulDivBusy
- Stall = LoadUse || BrEx || BrMem || HiLo
- Freeze = (ExMemMemRead || ExMemMemWrite) && !DMemReady

A branch on a load result therefore stalls 2 cycles (BrEx, then BrMem). A branch on an ALU result stalls 1 cycle.

Outputs, same cycle, combinational from the inputs and registered state. Freeze has priority:
- Freeze=1: PCWrite=0, IfIdWrite=0, PipeWrite=0, IdExBubble=0, IfIdFlush=0.
- else Stall=1: PCWrite=0, IfIdWrite=0, IdExBubble=1, PipeWrite=1, IfIdFlush=0.
- else: PCWrite=1, IfIdWrite=1, PipeWrite=1, IdExBubble=0, IfIdFlush = Branch && BranchTaken.

Mul/div FSM (states IDLE, BUSY; counter MdCnt, width clog2(MULDIV_LAT+1)):
- IDLE: if IdExMulDiv && !Freeze && MULDIV_LAT!=0, go to BUSY with MdCnt=MULDIV_LAT.
- BUSY: MdCnt decrements every cycle, including during Freeze. When MdCnt==1, go to IDLE next cycle.
- MulDivBusy = (state==BUSY). It is registered, so it asserts the cycle after the mul/div leaves EX.
- A second mul/div cannot reach EX while BUSY, because it is stalled by HiLo. If it does anyway, it is ignored.

StallCount:
- +1 on each clk edge where Stall||Freeze.
- Holds at 2^CNT_W-1 once it reaches that value.

Reset:
- While rst=1: state=IDLE, MdCnt=0, StallCount=0, PCWrite=0, IfIdWrite=0, PipeWrite=0, IdExBubble=1, IfIdFlush=0.
- The first cycle after release follows the normal rules.
- rst asserted during BUSY aborts to IDLE immediately.

Test Plan:
- lw $5 in EX (IdExMemRead=1, IdExRegDst=5), ID add with Rs=5 -> one cycle with PCWrite=0, IfIdWrite=0, IdExBubble=1. Next cycle, with IdExMemRead=0, all enables return to 1. StallCount=1.
- beq Rs=8 in ID. Cycle 1: load to $8 in EX. Cycle 2: the same load in MEM (ExMemMemRead=1, ExMemRegRd=8) -> two consecutive stall cycles, IfIdFlush=0 throughout. Cycle 3: BranchTaken=1 -> IfIdFlush=1, PCWrite=1.
- Dependences on register 0: IdExRegDst=0 with Rs=0 on a load, and ExMemRegRd=0 with a branch on $0 -> no stall in either case.
- MULDIV_LAT=4: IdExMulDiv pulse, then mflo held in ID -> MulDivBusy high for exactly 4 cycles and mflo stalled for 4 cycles. Then issue proceeds.
- Store in MEM with DMemReady=0 for 3 cycles while a load-use hazard is also present -> PipeWrite=0 and IdExBubble=0 for 3 cycles. Then 1 bubble cycle. StallCount=4.
- CNT_W=2: force 5 stall cycles -> StallCount reads 3 and holds. Assert rst mid-BUSY -> MulDivBusy=0 and StallCount=0 immediately.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector and pipeline-freeze controller.
// Finds dependences that forwarding cannot cover: load-use, a branch compared in ID,
// and HI/LO use while mul/div is busy. For these it stalls IF/ID and inserts an
// ID/EX bubble. It freezes every stage while data memory is not ready, and it keeps
// a saturating count of stalled or frozen cycles.
//
// Enable semantics: an enable at 1 means the stage register captures at the next clk
// edge. Freeze outranks Stall so that a frozen pipeline never loses a bubble.
module hazard_stall_unit #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IfIdRegRs,
    input  logic [4:0]       IfIdRegRt,
    input  logic             IfIdUsesRt,
    input  logic             IfIdUsesHiLo,
    input  logic             Branch,
    input  logic             BranchTaken,
    input  logic             IdExMemRead,
    input  logic             IdExRegWrite,
    input  logic [4:0]       IdExRegDst,
    input  logic             IdExMulDiv,
    input  logic             ExMemMemRead,
    input  logic             ExMemMemWrite,
    input  logic [4:0]       ExMemRegRd,
    input  logic             DMemReady,
    output logic             PCWrite,
    output logic             IfIdWrite,
    output logic             IfIdFlush,
    output logic             IdExBubble,
    output logic             PipeWrite,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCount
);

    // A latency of 0 still needs a 1-bit counter to stay a legal vector.
    localparam int MD_W = (MULDIV_LAT > 0) ? $clog2(MULDIV_LAT + 1) : 1;
    localparam logic [MD_W-1:0]  MD_LOAD = MD_W'(MULDIV_LAT);
    localparam logic [MD_W-1:0]  MD_ONE  = MD_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    mdState_t        mdState;
    mdState_t        mdStateNext;
    logic [MD_W-1:0] mdCnt;
    logic [MD_W-1:0] mdCntNext;

    logic matchExRs;
    logic matchExRt;
    logic matchMemRs;
    logic matchMemRt;
    logic srcRt;
    logic loadUse;
    logic brEx;
    logic brMem;
    logic hiLo;
    logic stall;
    logic freeze;

    // Register 0 is hardwired to zero, so it never forms a dependence.
    assign matchExRs  = (IdExRegDst != 5'd0) && (IdExRegDst == IfIdRegRs);
    assign matchExRt  = (IdExRegDst != 5'd0) && (IdExRegDst == IfIdRegRt);
    assign matchMemRs = (ExMemRegRd != 5'd0) && (ExMemRegRd == IfIdRegRs);
    assign matchMemRt = (ExMemRegRd != 5'd0) && (ExMemRegRd == IfIdRegRt);

    // A branch always reads rt, whether or not the decoder flags it.
    assign srcRt = IfIdUsesRt || Branch;

    // The ID compare needs its operands one stage earlier than the ALU does.
    // An ALU result in EX costs one cycle. A load costs two: EX, then MEM.
    assign loadUse = IdExMemRead && (matchExRs || (srcRt && matchExRt));
    assign brEx    = Branch && (IdExRegWrite || IdExMemRead) && (matchExRs || matchExRt);
    assign brMem   = Branch && ExMemMemRead && (matchMemRs || matchMemRt);
    assign hiLo    = IfIdUsesHiLo && MulDivBusy;
    assign stall   = loadUse || brEx || brMem || hiLo;
    assign freeze  = (ExMemMemRead || ExMemMemWrite) && !DMemReady;

    assign MulDivBusy = (mdState == BUSY);

    // Pipeline enables: reset, then freeze, then stall, then normal issue.
    always_comb begin
        PCWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        PipeWrite  = 1'b1;
        IdExBubble = 1'b0;
        IfIdFlush  = 1'b0;
        if (rst) begin
            PCWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            PipeWrite  = 1'b0;
            IdExBubble = 1'b1;
        end else if (freeze) begin
            PCWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            PipeWrite  = 1'b0;
        end else if (stall) begin
            PCWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            IdExBubble = 1'b1;
        end else begin
            IfIdFlush  = Branch && BranchTaken;
        end
    end

    // Mul/div busy tracker: next state and next count.
    always_comb begin
        mdStateNext = mdState;
        mdCntNext   = mdCnt;
        case (mdState)
            IDLE: begin
                // A mul/div held in EX by a freeze has not left EX yet.
                if (IdExMulDiv && !freeze && (MULDIV_LAT != 0)) begin
                    mdStateNext = BUSY;
                    mdCntNext   = MD_LOAD;
                end
            end
            BUSY: begin
                // Counts down through freezes, because the unit runs on its own.
                // A mul/div that reaches EX in this state is ignored.
                mdCntNext = mdCnt - MD_ONE;
                if (mdCnt <= MD_ONE) begin
                    mdStateNext = IDLE;
                end
            end
            default: begin
                mdStateNext = IDLE;
                mdCntNext   = '0;
            end
        endcase
    end

    // Mul/div state register. An asynchronous reset aborts any busy period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdState <= IDLE;
            mdCnt   <= '0;
        end else begin
            mdState <= mdStateNext;
            mdCnt   <= mdCntNext;
        end
    end

    // Saturating count of cycles spent stalled or frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= '0;
        end else if ((stall || freeze) && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit.
// A default instance covers the hazards. A second instance with a 2-bit counter
// shares the same inputs and covers counter saturation.
module tb_hazard_stall_unit;

    // Control vector {PCWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeWrite}
    localparam logic [4:0] C_NORM   = 5'b11001;
    localparam logic [4:0] C_FLUSH  = 5'b11101;
    localparam logic [4:0] C_STALL  = 5'b00011;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_RESET  = 5'b00010;

    logic        clk;
    logic        rst;
    logic [4:0]  IfIdRegRs;
    logic [4:0]  IfIdRegRt;
    logic        IfIdUsesRt;
    logic        IfIdUsesHiLo;
    logic        Branch;
    logic        BranchTaken;
    logic        IdExMemRead;
    logic        IdExRegWrite;
    logic [4:0]  IdExRegDst;
    logic        IdExMulDiv;
    logic        ExMemMemRead;
    logic        ExMemMemWrite;
    logic [4:0]  ExMemRegRd;
    logic        DMemReady;

    logic        PCWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeWrite, MulDivBusy;
    logic [15:0] StallCount;
    logic        PCWrite2, IfIdWrite2, IfIdFlush2, IdExBubble2, PipeWrite2, MulDivBusy2;
    logic [1:0]  StallCount2;

    logic [4:0]  ctl;
    logic [5:0]  bctl;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    int exp_sat;

    assign ctl  = {PCWrite, IfIdWrite, IfIdFlush, IdExBubble, PipeWrite};
    assign bctl = {MulDivBusy, ctl};

    hazard_stall_unit #(.MULDIV_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdUsesRt(IfIdUsesRt),
        .IfIdUsesHiLo(IfIdUsesHiLo), .Branch(Branch), .BranchTaken(BranchTaken),
        .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExRegDst(IdExRegDst),
        .IdExMulDiv(IdExMulDiv), .ExMemMemRead(ExMemMemRead), .ExMemMemWrite(ExMemMemWrite),
        .ExMemRegRd(ExMemRegRd), .DMemReady(DMemReady),
        .PCWrite(PCWrite), .IfIdWrite(IfIdWrite), .IfIdFlush(IfIdFlush),
        .IdExBubble(IdExBubble), .PipeWrite(PipeWrite), .MulDivBusy(MulDivBusy),
        .StallCount(StallCount)
    );

    hazard_stall_unit #(.MULDIV_LAT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .IfIdRegRs(IfIdRegRs), .IfIdRegRt(IfIdRegRt), .IfIdUsesRt(IfIdUsesRt),
        .IfIdUsesHiLo(IfIdUsesHiLo), .Branch(Branch), .BranchTaken(BranchTaken),
        .IdExMemRead(IdExMemRead), .IdExRegWrite(IdExRegWrite), .IdExRegDst(IdExRegDst),
        .IdExMulDiv(IdExMulDiv), .ExMemMemRead(ExMemMemRead), .ExMemMemWrite(ExMemMemWrite),
        .ExMemRegRd(ExMemRegRd), .DMemReady(DMemReady),
        .PCWrite(PCWrite2), .IfIdWrite(IfIdWrite2), .IfIdFlush(IfIdFlush2),
        .IdExBubble(IdExBubble2), .PipeWrite(PipeWrite2), .MulDivBusy(MulDivBusy2),
        .StallCount(StallCount2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        IfIdRegRs     = 5'd0;
        IfIdRegRt     = 5'd0;
        IfIdUsesRt    = 1'b0;
        IfIdUsesHiLo  = 1'b0;
        Branch        = 1'b0;
        BranchTaken   = 1'b0;
        IdExMemRead   = 1'b0;
        IdExRegWrite  = 1'b0;
        IdExRegDst    = 5'd0;
        IdExMulDiv    = 1'b0;
        ExMemMemRead  = 1'b0;
        ExMemMemWrite = 1'b0;
        ExMemRegRd    = 5'd0;
        DMemReady     = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        // A load-use pattern during reset must not leak through.
        IdExMemRead = 1'b1; IdExRegDst = 5'd5; IfIdRegRs = 5'd5;
        @(negedge clk);
        checks++;
        if (bctl !== {1'b0, C_RESET}) begin
            failures++; $display("FAIL reset_ctl got=%b exp=%b", bctl, {1'b0, C_RESET});
        end
        next_cycle();
        checks++;
        if (StallCount !== 16'd0 || StallCount2 !== 2'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", StallCount, StallCount2);
        end
        clear_inputs();
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        checks++;
        if (bctl !== {1'b0, C_NORM}) begin
            failures++; $display("FAIL reset_release got=%b exp=%b", bctl, {1'b0, C_NORM});
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        IdExMemRead = 1'b1; IdExRegDst = 5'd5; IfIdRegRs = 5'd5;
        @(negedge clk);
        checks++;
        if (ctl !== C_STALL) begin
            failures++; $display("FAIL lu_stall got=%b exp=%b", ctl, C_STALL);
        end
        next_cycle(); exp_cnt++;
        clear_inputs();
        IdExRegWrite = 1'b1; IdExRegDst = 5'd5; IfIdRegRs = 5'd5;
        @(negedge clk);
        checks++;
        if (ctl !== C_NORM) begin
            failures++; $display("FAIL lu_release got=%b exp=%b", ctl, C_NORM);
        end
        next_cycle();
        checks++;
        if (StallCount !== 16'(exp_cnt)) begin
            failures++; $display("FAIL lu_cnt got=%0d exp=%0d", StallCount, exp_cnt);
        end
        // rt matches the load but the instruction does not read rt.
        clear_inputs();
        IdExMemRead = 1'b1; IdExRegDst = 5'd7; IfIdRegRs = 5'd3; IfIdRegRt = 5'd7;
        @(negedge clk);
        checks++;
        if (ctl !== C_NORM) begin
            failures++; $display("FAIL lu_rt_unused got=%b exp=%b", ctl, C_NORM);
        end
        next_cycle();
        IfIdUsesRt = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_STALL) begin
            failures++; $display("FAIL lu_rt_used got=%b exp=%b", ctl, C_STALL);
        end
        next_cycle(); exp_cnt++;
    endtask

    task automatic test_branch();
        // beq on a load result: one stall with the load in EX, one with it in MEM.
        clear_inputs();
        Branch = 1'b1; IfIdRegRs = 5'd8; IfIdRegRt = 5'd2;
        IdExMemRead = 1'b1; IdExRegWrite = 1'b1; IdExRegDst = 5'd8;
        @(negedge clk);
        checks++;
        if (ctl !== C_STALL) begin
            failures++; $display("FAIL br_load_ex got=%b exp=%b", ctl, C_STALL);
        end
        next_cycle(); exp_cnt++;
        clear_inputs();
        Branch = 1'b1; IfIdRegRs = 5'd8; IfIdRegRt = 5'd2;
        ExMemMemRead = 1'b1; ExMemRegRd = 5'd8;
        @(negedge clk);
        checks++;
        if (ctl !== C_STALL) begin
            failures++; $display("FAIL br_load_mem got=%b exp=%b", ctl, C_STALL);
        end
        next_cycle(); exp_cnt++;
        clear_inputs();
        Branch = 1'b1; BranchTaken = 1'b1; IfIdRegRs = 5'd8; IfIdRegRt = 5'd2;
        @(negedge clk);
        checks++;
        if (ctl !== C_FLUSH) begin
            failures++; $display("FAIL br_taken got=%b exp=%b", ctl, C_FLUSH);
        end
        next_cycle();
        // beq on an ALU result through rt: one stall, then the not-taken branch issues.
        clear_inputs();
        Branch = 1'b1; IfIdRegRs = 5'd4; IfIdRegRt = 5'd9;
        IdExRegWrite = 1'b1; IdExRegDst = 5'd9;
        @(negedge clk);
        checks++;
        if (ctl !== C_STALL) begin
            failures++; $display("FAIL br_alu_ex got=%b exp=%b", ctl, C_STALL);
        end
        next_cycle(); exp_cnt++;
        clear_inputs();
        Branch = 1'b1; IfIdRegRs = 5'd4; IfIdRegRt = 5'd9; ExMemRegRd = 5'd9;
        @(negedge clk);
        checks++;
        if (ctl !== C_NORM) begin
            failures++; $display("FAIL br_alu_mem got=%b exp=%b", ctl, C_NORM);
        end
        next_cycle();
        checks++;
        if (StallCount !== 16'(exp_cnt)) begin
            failures++; $display("FAIL br_cnt got=%0d exp=%0d", StallCount, exp_cnt);
        end
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        IdExMemRead = 1'b1; IdExRegDst = 5'd0; IfIdRegRs = 5'd0; IfIdUsesRt = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_NORM) begin
            failures++; $display("FAIL zero_load got=%b exp=%b", ctl, C_NORM);
        end
        next_cycle();
        clear_inputs();
        Branch = 1'b1; BranchTaken = 1'b1;
        ExMemMemRead = 1'b1; ExMemRegRd = 5'd0; IdExRegWrite = 1'b1; IdExRegDst = 5'd0;
        @(negedge clk);
        checks++;
        if (ctl !== C_FLUSH) begin
            failures++; $display("FAIL zero_branch got=%b exp=%b", ctl, C_FLUSH);
        end
        next_cycle();
    endtask

    task automatic test_muldiv();
        clear_inputs();
        IdExMulDiv = 1'b1;
        @(negedge clk);
        checks++;
        if (bctl !== {1'b0, C_NORM}) begin
            failures++; $display("FAIL md_issue got=%b exp=%b", bctl, {1'b0, C_NORM});
        end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            IfIdUsesHiLo = 1'b1;
            @(negedge clk);
            checks++;
            if (bctl !== {1'b1, C_STALL}) begin
                failures++; $display("FAIL md_busy_%0d got=%b exp=%b", i, bctl, {1'b1, C_STALL});
            end
            next_cycle(); exp_cnt++;
        end
        clear_inputs();
        IfIdUsesHiLo = 1'b1;
        @(negedge clk);
        checks++;
        if (bctl !== {1'b0, C_NORM}) begin
            failures++; $display("FAIL md_done got=%b exp=%b", bctl, {1'b0, C_NORM});
        end
        next_cycle();
        checks++;
        if (StallCount !== 16'(exp_cnt)) begin
            failures++; $display("FAIL md_cnt got=%0d exp=%0d", StallCount, exp_cnt);
        end
    endtask

    task automatic test_freeze();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            ExMemMemWrite = 1'b1; DMemReady = 1'b0;
            IdExMemRead = 1'b1; IdExRegDst = 5'd5; IfIdRegRs = 5'd5;
            @(negedge clk);
            checks++;
            if (ctl !== C_FREEZE) begin
                failures++; $display("FAIL frz_%0d got=%b exp=%b", i, ctl, C_FREEZE);
            end
            next_cycle(); exp_cnt++;
        end
        clear_inputs();
        IdExMemRead = 1'b1; IdExRegDst = 5'd5; IfIdRegRs = 5'd5;
        @(negedge clk);
        checks++;
        if (ctl !== C_STALL) begin
            failures++; $display("FAIL frz_bubble got=%b exp=%b", ctl, C_STALL);
        end
        next_cycle(); exp_cnt++;
        // A mul/div held in EX by a freeze must not start the busy period.
        clear_inputs();
        ExMemMemRead = 1'b1; ExMemRegRd = 5'd12; DMemReady = 1'b0; IdExMulDiv = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== C_FREEZE) begin
            failures++; $display("FAIL frz_md got=%b exp=%b", ctl, C_FREEZE);
        end
        next_cycle(); exp_cnt++;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bctl !== {1'b0, C_NORM}) begin
            failures++; $display("FAIL frz_md_idle got=%b exp=%b", bctl, {1'b0, C_NORM});
        end
        next_cycle();
        exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
        checks++;
        if (StallCount !== 16'(exp_cnt) || StallCount2 !== 2'(exp_sat)) begin
            failures++;
            $display("FAIL frz_cnt got=%0d/%0d exp=%0d/%0d", StallCount, StallCount2, exp_cnt, exp_sat);
        end
    endtask

    task automatic test_saturate_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            IdExMemRead = 1'b1; IdExRegDst = 5'd6; IfIdRegRs = 5'd6;
            next_cycle(); exp_cnt++;
            exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
            checks++;
            if (StallCount2 !== 2'(exp_sat) || StallCount !== 16'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_%0d got=%0d/%0d exp=%0d/%0d", i, StallCount2, StallCount, exp_sat, exp_cnt);
            end
        end
        clear_inputs();
        IdExMulDiv = 1'b1;
        next_cycle();
        clear_inputs();
        next_cycle();
        checks++;
        if (MulDivBusy !== 1'b1) begin
            failures++; $display("FAIL rst_pre_busy got=%b exp=1", MulDivBusy);
        end
        // Reset mid-cycle while busy: the effect must be immediate.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bctl !== {1'b0, C_RESET} || StallCount !== 16'd0 || StallCount2 !== 2'd0) begin
            failures++;
            $display("FAIL rst_busy got=%b cnt=%0d/%0d exp=%b cnt=0/0", bctl, StallCount, StallCount2, {1'b0, C_RESET});
        end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bctl !== {1'b0, C_NORM}) begin
            failures++; $display("FAIL rst_after got=%b exp=%b", bctl, {1'b0, C_NORM});
        end
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        #2;
        test_reset();
        test_load_use();
        test_branch();
        test_reg_zero();
        test_muldiv();
        test_freeze();
        test_saturate_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
